scr1_tcm_mp: RTL and testbench

Multi-bank, multi-port tightly-coupled memory for the SCR1 cluster. It serves the core instruction port, the core data port, and a dedicated accelerator master port. Storage is split into word-interleaved banks. The data and accelerator ports arbitrate per bank, so accesses to different banks proceed in the same cycle. It replaces the single-bank TCM, whose accelerator path was a static mux.

---
 rtl/scr1_tcm_mp.sv | 240 ++++++++++++++++++++++++
 tb/tb_scr1_tcm_mp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_mp.sv
// scr1_tcm_mp: word-interleaved multi-bank TCM shared by imem, dmem and accelerator.
// Optional macro SCR1_TCM_CORE_PRIO_EN: dmem-first priority with an acc starvation guard.
module scr1_tcm_mp #(
    parameter int unsigned TCM_SIZE     = 32'h00010000,
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned ACC_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_req_ack,
    output logic [31:0] imem_rdata,
    output logic [1:0]  imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_req_ack,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp,
    input  logic        acc_req,
    input  logic        acc_we,
    input  logic [31:0] acc_addr,
    input  logic [3:0]  acc_be,
    input  logic [31:0] acc_wdata,
    output logic        acc_req_ack,
    output logic [31:0] acc_rdata,
    output logic [1:0]  acc_resp
);

    localparam int unsigned AW    = $clog2(TCM_SIZE);
    localparam int unsigned WW    = AW - 2;
    localparam int unsigned WORDS = TCM_SIZE / 4;
    localparam int unsigned BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_OK     = 2'b01;
    localparam logic [1:0] RESP_ER     = 2'b10;
    localparam logic       CMD_WR      = 1'b1;
    localparam logic [1:0] W_BYTE      = 2'b00;
    localparam logic [1:0] W_HWORD     = 2'b01;
    localparam logic [1:0] W_WORD      = 2'b10;

    function automatic logic [BW-1:0] bank_of(input logic [WW-1:0] w);
        if (NUM_BANKS == 1) return '0;
        return w[BW-1:0];
    endfunction

    logic [31:0] mem_q [WORDS];

    logic [1:0]  imem_resp_q, imem_resp_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [1:0]  dmem_resp_q, dmem_resp_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic [1:0]  acc_resp_q, acc_resp_d;
    logic [31:0] acc_rdata_q, acc_rdata_d;

    logic          i_oor, d_oor, a_oor;
    logic [WW-1:0] i_widx, d_widx, a_widx;
    logic [BW-1:0] d_bank, a_bank;
    logic [31:0]   i_rword, d_rword, a_rword;
    logic [3:0]    d_be;
    logic [31:0]   d_wd;
    logic          d_bad, d_err, d_need, a_need;
    logic          d_gnt, a_gnt, d_we, a_we;

    logic [NUM_BANKS-1:0] dm_b, ac_b;
    logic [NUM_BANKS-1:0] d_gnt_b, a_gnt_b;

`ifdef SCR1_TCM_CORE_PRIO_EN
    localparam int unsigned CW = (ACC_MAX_WAIT > 0) ? $clog2(ACC_MAX_WAIT + 1) : 1;
    logic [CW-1:0] cnt_q [NUM_BANKS];
    logic [CW-1:0] cnt_d [NUM_BANKS];
`else
    localparam int unsigned unused_max_wait = ACC_MAX_WAIT;
    logic [NUM_BANKS-1:0] ptr_q, ptr_d;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[1:0], acc_addr[1:0]};

    assign i_oor  = (imem_addr >= TCM_SIZE);
    assign d_oor  = (dmem_addr >= TCM_SIZE);
    assign a_oor  = (acc_addr >= TCM_SIZE);
    assign i_widx = imem_addr[AW-1:2];
    assign d_widx = dmem_addr[AW-1:2];
    assign a_widx = acc_addr[AW-1:2];
    assign d_bank = bank_of(d_widx);
    assign a_bank = bank_of(a_widx);

    assign i_rword = mem_q[i_widx];
    assign d_rword = mem_q[d_widx];
    assign a_rword = mem_q[a_widx];

    always_comb begin
        d_be  = 4'h0;
        d_wd  = dmem_wdata;
        d_bad = 1'b0;
        case (dmem_width)
            W_BYTE: begin
                d_be = 4'b0001 << dmem_addr[1:0];
                d_wd = {4{dmem_wdata[7:0]}};
            end
            W_HWORD: begin
                d_be  = 4'b0011 << {dmem_addr[1], 1'b0};
                d_wd  = {2{dmem_wdata[15:0]}};
                d_bad = dmem_addr[0];
            end
            W_WORD: begin
                d_be  = 4'hF;
                d_bad = |dmem_addr[1:0];
            end
            default: d_bad = 1'b1;
        endcase
    end

    // Faulty requests are acked at once and never occupy a bank port.
    assign d_err  = d_oor | d_bad;
    assign d_need = dmem_req & ~d_err;
    assign a_need = acc_req & ~a_oor;

    always_comb begin
        dm_b = '0;
        ac_b = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            dm_b[b] = d_need && (d_bank == BW'(b));
            ac_b[b] = a_need && (a_bank == BW'(b));
        end
    end

    always_comb begin
        d_gnt_b = '0;
        a_gnt_b = '0;
`ifdef SCR1_TCM_CORE_PRIO_EN
        for (int b = 0; b < NUM_BANKS; b++) cnt_d[b] = cnt_q[b];
`else
        ptr_d = ptr_q;
`endif
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (dm_b[b] && ac_b[b]) begin
`ifdef SCR1_TCM_CORE_PRIO_EN
                if (cnt_q[b] == CW'(ACC_MAX_WAIT)) a_gnt_b[b] = 1'b1;
                else d_gnt_b[b] = 1'b1;
`else
                // ptr 0 favours the core; it flips to the loser after a contended grant.
                if (ptr_q[b]) a_gnt_b[b] = 1'b1;
                else d_gnt_b[b] = 1'b1;
                ptr_d[b] = ~ptr_q[b];
`endif
            end else begin
                d_gnt_b[b] = dm_b[b];
                a_gnt_b[b] = ac_b[b];
            end
`ifdef SCR1_TCM_CORE_PRIO_EN
            if (a_gnt_b[b]) cnt_d[b] = '0;
            else if (ac_b[b] && (cnt_q[b] != CW'(ACC_MAX_WAIT)))
                cnt_d[b] = cnt_q[b] + 1'b1;
`endif
        end
    end

    assign d_gnt = |d_gnt_b;
    assign a_gnt = |a_gnt_b;
    assign d_we  = d_gnt & (dmem_cmd == CMD_WR);
    assign a_we  = a_gnt & acc_we;

    assign imem_req_ack = 1'b1;
    assign dmem_req_ack = dmem_req & (d_err | d_gnt);
    assign acc_req_ack  = acc_req & (a_oor | a_gnt);

    // Granted ports of one bank never collide, so two byte-lane writers suffice.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (d_we && d_be[k]) mem_q[d_widx][8*k +: 8] <= d_wd[8*k +: 8];
                if (a_we && acc_be[k]) mem_q[a_widx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        imem_resp_d  = RESP_NOTRDY;
        imem_rdata_d = imem_rdata_q;
        dmem_resp_d  = RESP_NOTRDY;
        dmem_rdata_d = dmem_rdata_q;
        acc_resp_d   = RESP_NOTRDY;
        acc_rdata_d  = acc_rdata_q;
        if (imem_req) begin
            imem_resp_d  = i_oor ? RESP_ER : RESP_OK;
            imem_rdata_d = i_oor ? 32'h0 : i_rword;
        end
        if (dmem_req_ack) begin
            dmem_resp_d  = d_err ? RESP_ER : RESP_OK;
            dmem_rdata_d = (d_err || dmem_cmd == CMD_WR) ? 32'h0
                         : (d_rword >> {dmem_addr[1:0], 3'b000});
        end
        if (acc_req_ack) begin
            acc_resp_d  = a_oor ? RESP_ER : RESP_OK;
            acc_rdata_d = (a_oor || acc_we) ? 32'h0 : a_rword;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_resp_q  <= RESP_NOTRDY;
            imem_rdata_q <= '0;
            dmem_resp_q  <= RESP_NOTRDY;
            dmem_rdata_q <= '0;
            acc_resp_q   <= RESP_NOTRDY;
            acc_rdata_q  <= '0;
`ifdef SCR1_TCM_CORE_PRIO_EN
            for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
`else
            ptr_q <= '0;
`endif
        end else begin
            imem_resp_q  <= imem_resp_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_resp_q  <= dmem_resp_d;
            dmem_rdata_q <= dmem_rdata_d;
            acc_resp_q   <= acc_resp_d;
            acc_rdata_q  <= acc_rdata_d;
`ifdef SCR1_TCM_CORE_PRIO_EN
            for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= cnt_d[b];
`else
            ptr_q <= ptr_d;
`endif
        end
    end

    assign imem_resp  = imem_resp_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_resp  = dmem_resp_q;
    assign dmem_rdata = dmem_rdata_q;
    assign acc_resp   = acc_resp_q;
    assign acc_rdata  = acc_rdata_q;

endmodule

// File: tb/tb_scr1_tcm_mp.sv
// tb_scr1_tcm_mp: directed checks of scr1_tcm_mp (default 64 KiB, 2 banks).
// Contention expectations switch with SCR1_TCM_CORE_PRIO_EN.
module tb_scr1_tcm_mp;

    localparam logic [1:0] NOTRDY = 2'b00;
    localparam logic [1:0] OK     = 2'b01;
    localparam logic [1:0] ER     = 2'b10;
    localparam logic       RD     = 1'b0;
    localparam logic       WR     = 1'b1;
    localparam logic [1:0] BYTE   = 2'b00;
    localparam logic [1:0] HWORD  = 2'b01;
    localparam logic [1:0] WORD   = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic        dmem_req = 1'b0;
    logic        dmem_cmd = 1'b0;
    logic [1:0]  dmem_width = 2'b10;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        acc_req = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [3:0]  acc_be = '0;
    logic [31:0] acc_wdata = '0;
    logic        acc_req_ack;
    logic [31:0] acc_rdata;
    logic [1:0]  acc_resp;

    int n_cmp = 0;
    int n_err = 0;
    logic d_ack_s, a_ack_s;

    always #5 clk = ~clk;

    scr1_tcm_mp dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_req_ack(imem_req_ack), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
        .acc_be(acc_be), .acc_wdata(acc_wdata),
        .acc_req_ack(acc_req_ack), .acc_rdata(acc_rdata), .acc_resp(acc_resp)
    );

    task automatic clr();
        imem_req = 1'b0;
        dmem_req = 1'b0;
        acc_req  = 1'b0;
    endtask

    task automatic set_d(input logic c, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd);
        dmem_req = 1'b1; dmem_cmd = c; dmem_width = w;
        dmem_addr = a; dmem_wdata = wd;
    endtask

    task automatic set_a(input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        acc_req = 1'b1; acc_we = we; acc_addr = a;
        acc_be = be; acc_wdata = wd;
    endtask

    // One dmem access; outputs are left stable for the caller to inspect.
    task automatic d_cycle(input logic c, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        set_d(c, w, a, wd);
        #1 d_ack_s = dmem_req_ack;
        @(posedge clk);
        #1 dmem_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (imem_resp !== NOTRDY) begin n_err++; $display("FAIL rst_iresp: got %h exp %h", imem_resp, NOTRDY); end
        n_cmp++; if (dmem_resp !== NOTRDY) begin n_err++; $display("FAIL rst_dresp: got %h exp %h", dmem_resp, NOTRDY); end
        n_cmp++; if (acc_resp !== NOTRDY) begin n_err++; $display("FAIL rst_aresp: got %h exp %h", acc_resp, NOTRDY); end
        n_cmp++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_drdata: got %h exp 0", dmem_rdata); end
        n_cmp++; if (acc_rdata !== 32'h0) begin n_err++; $display("FAIL rst_ardata: got %h exp 0", acc_rdata); end
        n_cmp++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_irdata: got %h exp 0", imem_rdata); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (imem_resp !== NOTRDY) begin n_err++; $display("FAIL idle_iresp: got %h exp %h", imem_resp, NOTRDY); end
        n_cmp++; if (dmem_resp !== NOTRDY) begin n_err++; $display("FAIL idle_dresp: got %h exp %h", dmem_resp, NOTRDY); end
        n_cmp++; if (acc_resp !== NOTRDY) begin n_err++; $display("FAIL idle_aresp: got %h exp %h", acc_resp, NOTRDY); end
    endtask

    task automatic test_parallel_banks();
        @(negedge clk);
        set_d(WR, WORD, 32'h0, 32'hDEADBEEF);
        set_a(1'b1, 32'h4, 4'hF, 32'h12345678);
        #1;
        n_cmp++; if (dmem_req_ack !== 1'b1) begin n_err++; $display("FAIL par_dack: got %b exp 1", dmem_req_ack); end
        n_cmp++; if (acc_req_ack !== 1'b1) begin n_err++; $display("FAIL par_aack: got %b exp 1", acc_req_ack); end
        @(posedge clk);
        #1;
        n_cmp++; if (dmem_resp !== OK) begin n_err++; $display("FAIL par_dresp: got %h exp %h", dmem_resp, OK); end
        n_cmp++; if (acc_resp !== OK) begin n_err++; $display("FAIL par_aresp: got %h exp %h", acc_resp, OK); end
        clr();
        @(negedge clk);
        set_d(RD, WORD, 32'h4, 32'h0);
        set_a(1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++; if ({dmem_req_ack, acc_req_ack} !== 2'b11) begin n_err++; $display("FAIL par_rdack: got %b exp 11", {dmem_req_ack, acc_req_ack}); end
        @(posedge clk);
        #1;
        n_cmp++; if (dmem_rdata !== 32'h12345678) begin n_err++; $display("FAIL par_drd: got %h exp 12345678", dmem_rdata); end
        n_cmp++; if (acc_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL par_ard: got %h exp deadbeef", acc_rdata); end
        clr();
        @(posedge clk);
        #1;
        n_cmp++; if (dmem_resp !== NOTRDY) begin n_err++; $display("FAIL par_dhold: got %h exp %h", dmem_resp, NOTRDY); end
        n_cmp++; if (acc_resp !== NOTRDY) begin n_err++; $display("FAIL par_ahold: got %h exp %h", acc_resp, NOTRDY); end
    endtask

    task automatic test_imem();
        @(negedge clk);
        imem_req = 1'b1; imem_addr = 32'h0;
        #1;
        n_cmp++; if (imem_req_ack !== 1'b1) begin n_err++; $display("FAIL imem_ack: got %b exp 1", imem_req_ack); end
        @(posedge clk);
        #1;
        n_cmp++; if (imem_resp !== OK) begin n_err++; $display("FAIL imem_resp: got %h exp %h", imem_resp, OK); end
        n_cmp++; if (imem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL imem_rd0: got %h exp deadbeef", imem_rdata); end
        @(negedge clk);
        imem_addr = 32'h4;
        set_d(WR, WORD, 32'h4, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        clr();
        n_cmp++; if (imem_rdata !== 32'h12345678) begin n_err++; $display("FAIL imem_rbw: got %h exp 12345678", imem_rdata); end
        n_cmp++; if (dmem_resp !== OK) begin n_err++; $display("FAIL imem_dwr: got %h exp %h", dmem_resp, OK); end
        @(negedge clk);
        imem_req = 1'b1; imem_addr = 32'h4;
        @(posedge clk);
        #1;
        n_cmp++; if (imem_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL imem_rd4: got %h exp cafef00d", imem_rdata); end
        @(negedge clk);
        imem_addr = 32'h0001_0000;
        @(posedge clk);
        #1;
        clr();
        n_cmp++; if (imem_resp !== ER) begin n_err++; $display("FAIL imem_oor: got %h exp %h", imem_resp, ER); end
        n_cmp++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL imem_oor_rd: got %h exp 0", imem_rdata); end
    endtask

    task automatic test_width();
        d_cycle(WR, WORD, 32'h10, 32'h11223344);
        d_cycle(WR, BYTE, 32'h13, 32'h000000A5);
        n_cmp++; if (dmem_resp !== OK) begin n_err++; $display("FAIL w_bwr: got %h exp %h", dmem_resp, OK); end
        d_cycle(RD, WORD, 32'h10, 32'h0);
        n_cmp++; if (dmem_rdata !== 32'hA5223344) begin n_err++; $display("FAIL w_word: got %h exp a5223344", dmem_rdata); end
        d_cycle(RD, HWORD, 32'h12, 32'h0);
        n_cmp++; if (dmem_rdata !== 32'h0000A522) begin n_err++; $display("FAIL w_hrd: got %h exp 0000a522", dmem_rdata); end
        d_cycle(RD, BYTE, 32'h11, 32'h0);
        n_cmp++; if (dmem_rdata !== 32'h00A52233) begin n_err++; $display("FAIL w_brd: got %h exp 00a52233", dmem_rdata); end
        d_cycle(WR, HWORD, 32'h12, 32'h7777BEEF);
        d_cycle(RD, WORD, 32'h10, 32'h0);
        n_cmp++; if (dmem_rdata !== 32'hBEEF3344) begin n_err++; $display("FAIL w_hwr: got %h exp beef3344", dmem_rdata); end
    endtask

    task automatic test_errors();
        d_cycle(RD, WORD, 32'h0001_0000, 32'h0);
        n_cmp++; if (d_ack_s !== 1'b1) begin n_err++; $display("FAIL e_oor_ack: got %b exp 1", d_ack_s); end
        n_cmp++; if (dmem_resp !== ER) begin n_err++; $display("FAIL e_oor_resp: got %h exp %h", dmem_resp, ER); end
        n_cmp++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL e_oor_rd: got %h exp 0", dmem_rdata); end
        d_cycle(WR, HWORD, 32'h1, 32'h0000FFFF);
        n_cmp++; if (dmem_resp !== ER) begin n_err++; $display("FAIL e_mis_resp: got %h exp %h", dmem_resp, ER); end
        d_cycle(RD, WORD, 32'h0, 32'h0);
        n_cmp++; if (dmem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL e_mis_mem: got %h exp deadbeef", dmem_rdata); end
        d_cycle(RD, WORD, 32'h2, 32'h0);
        n_cmp++; if (dmem_resp !== ER) begin n_err++; $display("FAIL e_wmis: got %h exp %h", dmem_resp, ER); end
        @(negedge clk);
        set_a(1'b0, 32'h0001_0004, 4'h0, 32'h0);
        #1 a_ack_s = acc_req_ack;
        @(posedge clk);
        #1;
        clr();
        n_cmp++; if (a_ack_s !== 1'b1) begin n_err++; $display("FAIL e_aoor_ack: got %b exp 1", a_ack_s); end
        n_cmp++; if (acc_resp !== ER) begin n_err++; $display("FAIL e_aoor_resp: got %h exp %h", acc_resp, ER); end
        n_cmp++; if (acc_rdata !== 32'h0) begin n_err++; $display("FAIL e_aoor_rd: got %h exp 0", acc_rdata); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_d(RD, WORD, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        n_cmp++; if (dmem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_rd0: got %h exp deadbeef", dmem_rdata); end
        @(negedge clk);
        dmem_addr = 32'h10;
        @(posedge clk);
        #1;
        clr();
        n_cmp++; if (dmem_resp !== OK) begin n_err++; $display("FAIL b2b_resp: got %h exp %h", dmem_resp, OK); end
        n_cmp++; if (dmem_rdata !== 32'hBEEF3344) begin n_err++; $display("FAIL b2b_rd1: got %h exp beef3344", dmem_rdata); end
        @(posedge clk);
        #1;
        n_cmp++; if (dmem_resp !== NOTRDY) begin n_err++; $display("FAIL b2b_idle: got %h exp %h", dmem_resp, NOTRDY); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_w [10];
        logic [1:0] got, ew;
        int n_exp, d_left, a_left;
        d_cycle(WR, WORD, 32'h8, 32'h0BADF00D);
        for (int i = 0; i < 10; i++) exp_w[i] = 2'b00;
`ifdef SCR1_TCM_CORE_PRIO_EN
        n_exp = 10; d_left = 8; a_left = 2;
        for (int i = 0; i < 10; i++) exp_w[i] = (i == 4 || i == 9) ? 2'b01 : 2'b10;
`else
        n_exp = 4; d_left = 2; a_left = 2;
        exp_w[0] = 2'b10; exp_w[1] = 2'b01; exp_w[2] = 2'b10; exp_w[3] = 2'b01;
`endif
        for (int c = 0; c < n_exp + 4; c++) begin
            if (d_left == 0 && a_left == 0) break;
            ew = (c < n_exp) ? exp_w[c] : 2'b00;
            @(negedge clk);
            clr();
            if (d_left > 0) set_d(RD, WORD, 32'h8, 32'h0);
            if (a_left > 0) set_a(1'b0, 32'h8, 4'h0, 32'h0);
            #1 got = {dmem_req_ack, acc_req_ack};
            n_cmp++; if (got !== ew) begin n_err++; $display("FAIL cont_gnt[%0d]: got %b exp %b", c, got, ew); end
            @(posedge clk);
            #1;
            n_cmp++; if (dmem_resp !== (ew[1] ? OK : NOTRDY)) begin n_err++; $display("FAIL cont_dresp[%0d]: got %h exp %h", c, dmem_resp, ew[1] ? OK : NOTRDY); end
            n_cmp++; if (acc_resp !== (ew[0] ? OK : NOTRDY)) begin n_err++; $display("FAIL cont_aresp[%0d]: got %h exp %h", c, acc_resp, ew[0] ? OK : NOTRDY); end
            if (ew[0]) begin
                n_cmp++; if (acc_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL cont_ard[%0d]: got %h exp 0badf00d", c, acc_rdata); end
            end
            if (got[1]) d_left--;
            if (got[0]) a_left--;
        end
        clr();
        n_cmp++; if (d_left != 0 || a_left != 0) begin n_err++; $display("FAIL cont_timeout: got %0d/%0d left exp 0/0", d_left, a_left); end
    endtask

    task automatic test_reset_mid();
        d_cycle(WR, WORD, 32'h20, 32'h11223344);
        @(negedge clk);
        set_d(RD, WORD, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        n_cmp++; if (dmem_resp !== OK) begin n_err++; $display("FAIL rm_pre: got %h exp %h", dmem_resp, OK); end
        rst = 1'b1;
        #1;
        n_cmp++; if (dmem_resp !== NOTRDY) begin n_err++; $display("FAIL rm_resp: got %h exp %h", dmem_resp, NOTRDY); end
        n_cmp++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL rm_rdata: got %h exp 0", dmem_rdata); end
        set_d(WR, WORD, 32'h20, 32'hFFFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dmem_resp !== NOTRDY) begin n_err++; $display("FAIL rm_hold: got %h exp %h", dmem_resp, NOTRDY); end
        @(negedge clk);
        clr();
        rst = 1'b0;
        d_cycle(RD, WORD, 32'h20, 32'h0);
        n_cmp++; if (dmem_rdata !== 32'h11223344) begin n_err++; $display("FAIL rm_mem: got %h exp 11223344", dmem_rdata); end
    endtask

    initial begin
        test_reset();
        test_parallel_banks();
        test_imem();
        test_width();
        test_errors();
        test_back_to_back();
        test_contention();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
